sha_dispatch: RTL and testbench
===============================

# sha_dispatch

Packet-level scheduler that shares a pool of asynchronous SHA engines between back-to-back packets on one switch-side AXI-Stream input. Each packet goes whole to one engine, chosen round-robin among engines with free credit. Digests return on a single output in the original packet order. Sits between the crossbar data buffer and NUM_ENGINES SHA engine instances, in the `clk` domain.

## Interface
- DATA_WIDTH, 512, packet data width
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- NUM_ENGINES, 4, number of SHA engines (2..8)
- IDX_WIDTH, $clog2(NUM_ENGINES), engine index width
- MAX_OUTSTANDING, 4, max packets in flight per engine (1..15)
- ORDER_DEPTH, 16, order FIFO entries (power of 2, ≥ NUM_ENGINES*MAX_OUTSTANDING recommended)

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  DATA_WIDTH/KEEP_WIDTH/1/1/1  packet input
- m_eng_tdata/tkeep/tlast  out  DATA_WIDTH/KEEP_WIDTH/1  shared broadcast to all engines
- m_eng_tvalid  out  NUM_ENGINES  one-hot per-engine valid
- m_eng_tready  in  NUM_ENGINES  per-engine ready
- s_dig_tdata  in  NUM_ENGINES*512  engine digests, engine i at [512*i +: 512]
- s_dig_tvalid  in  NUM_ENGINES  digest valid
- s_dig_tready  out  NUM_ENGINES  digest ready
- m_digest_tdata  out  512  in-order digest
- m_digest_tid  out  IDX_WIDTH  engine that produced it
- m_digest_tvalid/tready  out/in  1  output handshake
- busy  out  1  any credit nonzero or state STREAM

## Operation
- Input FSM states: IDLE and STREAM.
- IDLE: s_axis_tready=0. An engine is eligible when credit[i] < MAX_OUTSTANDING. A grant needs the order FIFO not full and at least one eligible engine.
- Round-robin search starts at rr_ptr+1 mod NUM_ENGINES. On a grant, in the same edge:
  - sel←winner, rr_ptr←winner
  - push winner to the order FIFO
  - credit[winner]++
  - state←STREAM
- A grant does not wait for s_axis_tvalid.
- STREAM:
  - m_eng_tdata/tkeep/tlast = s_axis inputs
  - m_eng_tvalid[sel] = s_axis_tvalid, all other bits 0
  - s_axis_tready = m_eng_tready[sel]
  - A handshake with tlast=1 returns the FSM to IDLE.
- Output path, all combinational from order FIFO head h:
  - m_digest_tvalid = !empty && s_dig_tvalid[h]
  - m_digest_tdata = digest of engine h; m_digest_tid = h
  - s_dig_tready[h] = m_digest_tready && !empty; all other bits 0
- Digest handshake: pop the FIFO and credit[h]--.
- A non-head engine that finishes early holds its digest until it becomes head.
- Grant increment and digest decrement on the same engine in the same cycle: credit unchanged.
- Credit counters are $clog2(MAX_OUTSTANDING+1) bits and never wrap.
- Order FIFO push and pop in the same cycle is legal at any occupancy, including full-with-pop: no push is possible when full, because no grant is issued.
- A digest valid with the order FIFO empty is ignored and never readied.

## Timing
- Reset values: state=IDLE, rr_ptr=NUM_ENGINES-1 (first grant goes to engine 0), credits=0, FIFO empty.
- Outputs in reset: s_axis_tready=0, m_eng_tvalid=0, s_dig_tready=0, m_digest_tvalid=0, busy=0.
- Grant takes 1 cycle in IDLE. The first beat can be accepted in the cycle after the grant edge.
- Packet overhead is 1 bubble cycle: tlast accepted at edge N, next grant at edge N+1, next first beat at edge N+2.
- Data path adds 0 register stages; s_axis to m_eng is combinational.
- Digest path latency is 0 cycles from s_dig_tvalid[h] to m_digest_tvalid.
- rst asserted mid-packet aborts immediately and returns all state to reset values. Engines share rst and reset together. Partial packets are dropped.

## Configuration
- Macro: SHA_DISPATCH_STATS_EN.
- Defined:
  - Adds output stat_pkt_count (NUM_ENGINES*32 bits): per-engine granted-packet counters, incremented at grant.
  - Adds output stat_stall_cycles (32 bits): counts cycles in IDLE where s_axis_tvalid=1 but no grant occurs.
  - All counters reset to 0 on rst and saturate at 2^32-1.
- Not defined: those ports and counters do not exist; all other behaviour is identical.

## Test plan
- Single 3-beat packet, all engines ready, digest 0xAB..AB returned 10 cycles later:
  - engine 0 receives 3 beats starting the cycle after the grant
  - m_digest_tdata=0xAB..AB, tid=0, busy drops to 0 after pop
- Four 1-beat packets back-to-back:
  - grants go to engines 0,1,2,3
  - tready pattern 0,1,0,1,… (1 bubble per packet)
- Engines finish in order 3,1,0,2:
  - m_digest_tid output order is 0,1,2,3
  - engine 3's digest waits with s_dig_tready[3]=0 until three pops complete
- NUM_ENGINES=2, MAX_OUTSTANDING=1, no digests returned:
  - third packet stalls in IDLE
  - first digest pop grants engine 0 on the next edge
- rst asserted during beat 2 of a 4-beat packet:
  - next cycle all outputs are 0 and credits are 0
  - after release the next packet goes to engine 0
- With SHA_DISPATCH_STATS_EN, 5 packets on 4 engines:
  - stat_pkt_count = {0:2, 1:1, 2:1, 3:1}

Source files
------------

// File: rtl/sha_dispatch.sv
// sha_dispatch: shares NUM_ENGINES asynchronous SHA engines between packets
// arriving on one AXI-Stream input. Each packet is sent whole to one engine,
// chosen round-robin among engines with free credit. Digests are returned on
// a single output in original packet order, using an order FIFO of engine ids.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   s_axis_*                       packet input (tdata/tkeep/tvalid/tready/tlast)
//   m_eng_tdata/tkeep/tlast        broadcast to all engines
//   m_eng_tvalid/tready            per-engine handshake (valid is one-hot)
//   s_dig_tdata/tvalid/tready      per-engine digests, engine i at [512*i +: 512]
//   m_digest_tdata/tid/tvalid/tready  in-order digest output, tid = engine
//   busy                           any credit outstanding or a packet streaming
// Optional (macro SHA_DISPATCH_STATS_EN):
//   stat_pkt_count                 per-engine granted-packet counters (32b each)
//   stat_stall_cycles              IDLE cycles with input valid but no grant
module sha_dispatch #(
    parameter int DATA_WIDTH      = 512,
    parameter int KEEP_WIDTH      = DATA_WIDTH/8,
    parameter int NUM_ENGINES     = 4,
    parameter int IDX_WIDTH       = $clog2(NUM_ENGINES),
    parameter int MAX_OUTSTANDING = 4,
    parameter int ORDER_DEPTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [DATA_WIDTH-1:0]      m_eng_tdata,
    output logic [KEEP_WIDTH-1:0]      m_eng_tkeep,
    output logic                       m_eng_tlast,
    output logic [NUM_ENGINES-1:0]     m_eng_tvalid,
    input  logic [NUM_ENGINES-1:0]     m_eng_tready,
    input  logic [NUM_ENGINES*512-1:0] s_dig_tdata,
    input  logic [NUM_ENGINES-1:0]     s_dig_tvalid,
    output logic [NUM_ENGINES-1:0]     s_dig_tready,
    output logic [511:0]               m_digest_tdata,
    output logic [IDX_WIDTH-1:0]       m_digest_tid,
    output logic                       m_digest_tvalid,
    input  logic                       m_digest_tready,
    output logic                       busy
`ifdef SHA_DISPATCH_STATS_EN
    ,
    output logic [NUM_ENGINES*32-1:0]  stat_pkt_count,
    output logic [31:0]                stat_stall_cycles
`endif
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = $clog2(ORDER_DEPTH);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               r_state;
    logic [IDX_WIDTH-1:0] r_sel;
    logic [IDX_WIDTH-1:0] r_rr_ptr;
    logic [CW-1:0]        r_credit [NUM_ENGINES];
    logic [IDX_WIDTH-1:0] r_fifo   [ORDER_DEPTH];
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;

    logic                 w_stream;
    logic                 w_empty;
    logic                 w_full;
    logic [IDX_WIDTH-1:0] w_head;
    logic                 w_found;
    logic [IDX_WIDTH-1:0] w_winner;
    logic [IDX_WIDTH-1:0] w_cand;
    logic                 w_grant;
    logic                 w_pop;
    logic                 w_last_hs;
    logic                 w_any_credit;
    logic [511:0]         w_dig_data;

    assign w_stream = (r_state == STREAM);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    // Extra pointer bit distinguishes full from empty.
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head   = r_fifo[r_rd_ptr[AW-1:0]];

    // Round-robin: first engine with free credit, starting after the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_ENGINES; k++) begin
            w_cand = IDX_WIDTH'((int'(r_rr_ptr) + k) % NUM_ENGINES);
            if (!w_found && (r_credit[w_cand] < MAX_C)) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // A grant does not wait for input valid; it reserves the next engine early.
    assign w_grant   = (r_state == IDLE) && !w_full && w_found;
    assign w_last_hs = s_axis_tvalid && s_axis_tready && s_axis_tlast;
    assign w_pop     = m_digest_tvalid && m_digest_tready;

    always_comb begin
        w_dig_data   = '0;
        w_any_credit = 1'b0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (w_head == IDX_WIDTH'(i))
                w_dig_data = s_dig_tdata[512*i +: 512];
            w_any_credit = w_any_credit | (r_credit[i] != '0);
        end
    end

    // Data path is combinational; outputs are forced quiet outside STREAM.
    assign m_eng_tdata   = w_stream ? s_axis_tdata : '0;
    assign m_eng_tkeep   = w_stream ? s_axis_tkeep : '0;
    assign m_eng_tlast   = w_stream && s_axis_tlast;
    assign m_eng_tvalid  = (w_stream && s_axis_tvalid) ? (NUM_ENGINES'(1) << r_sel) : '0;
    assign s_axis_tready = w_stream && m_eng_tready[r_sel];

    // Only the FIFO head engine is ever readied; others hold their digests.
    assign m_digest_tvalid = !w_empty && s_dig_tvalid[w_head];
    assign m_digest_tdata  = w_empty ? '0 : w_dig_data;
    assign m_digest_tid    = w_empty ? '0 : w_head;
    assign s_dig_tready    = (m_digest_tready && !w_empty) ? (NUM_ENGINES'(1) << w_head) : '0;

    assign busy = w_stream || w_any_credit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_rr_ptr <= IDX_WIDTH'(NUM_ENGINES - 1);
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < NUM_ENGINES; i++) r_credit[i] <= '0;
            for (int i = 0; i < ORDER_DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_sel                    <= w_winner;
                        r_rr_ptr                 <= w_winner;
                        r_fifo[r_wr_ptr[AW-1:0]] <= w_winner;
                        r_wr_ptr                 <= r_wr_ptr + 1'b1;
                        r_state                  <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_last_hs) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            // Grant can only hit an engine below MAX and a pop only an engine
            // with an entry in the FIFO, so the counters never wrap.
            for (int i = 0; i < NUM_ENGINES; i++) begin
                case ({w_grant && (w_winner == IDX_WIDTH'(i)),
                       w_pop && (w_head == IDX_WIDTH'(i))})
                    2'b10:   r_credit[i] <= r_credit[i] + CW'(1);
                    2'b01:   r_credit[i] <= r_credit[i] - CW'(1);
                    default: r_credit[i] <= r_credit[i];
                endcase
            end
        end
    end

`ifdef SHA_DISPATCH_STATS_EN
    logic [NUM_ENGINES-1:0][31:0] r_pkt_cnt;
    logic [31:0]                  r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_ENGINES; i++)
                if (w_grant && (w_winner == IDX_WIDTH'(i)) && (r_pkt_cnt[i] != '1))
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 32'd1;
            if ((r_state == IDLE) && s_axis_tvalid && !w_grant && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stat_pkt_count    = r_pkt_cnt;
    assign stat_stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_sha_dispatch.sv
// Testbench for sha_dispatch: directed scenarios plus a randomized phase,
// checked against a packet-level model (credits, order queue, engine digests).
module tb_sha_dispatch;
    localparam int NE = 4;
    localparam int MO = 4;
    localparam int OD = 16;

    logic clk = 1'b0;
    logic rst;
    initial forever #5 clk = ~clk;

    logic [511:0] s_tdata;  logic [63:0] s_tkeep;  logic s_tvalid, s_tlast;
    logic         s_tready;
    logic [511:0] e_tdata;  logic [63:0] e_tkeep;  logic e_tlast;
    logic [NE-1:0] e_tvalid, e_tready;
    logic [NE*512-1:0] d_tdata; logic [NE-1:0] d_tvalid, d_tready;
    logic [511:0] o_tdata;  logic [1:0] o_tid;  logic o_tvalid, o_tready;
    logic         busy;
`ifdef SHA_DISPATCH_STATS_EN
    logic [NE*32-1:0] stat_pkt;  logic [31:0] stat_stall;
    logic [63:0]      b_stat_pkt; logic [31:0] b_stat_stall;
`endif

    sha_dispatch #(.NUM_ENGINES(NE), .MAX_OUTSTANDING(MO), .ORDER_DEPTH(OD)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_eng_tdata(e_tdata), .m_eng_tkeep(e_tkeep), .m_eng_tlast(e_tlast),
        .m_eng_tvalid(e_tvalid), .m_eng_tready(e_tready),
        .s_dig_tdata(d_tdata), .s_dig_tvalid(d_tvalid), .s_dig_tready(d_tready),
        .m_digest_tdata(o_tdata), .m_digest_tid(o_tid),
        .m_digest_tvalid(o_tvalid), .m_digest_tready(o_tready),
        .busy(busy)
`ifdef SHA_DISPATCH_STATS_EN
        , .stat_pkt_count(stat_pkt), .stat_stall_cycles(stat_stall)
`endif
    );

    // Second instance: 2 engines, 1 packet in flight each.
    logic         b_rst;
    logic [511:0] b_s_tdata;  logic [63:0] b_s_tkeep;  logic b_s_tvalid, b_s_tlast, b_s_tready;
    logic [511:0] b_e_tdata;  logic [63:0] b_e_tkeep;  logic b_e_tlast;
    logic [1:0]   b_e_tvalid, b_e_tready;
    logic [1023:0] b_d_tdata; logic [1:0] b_d_tvalid, b_d_tready;
    logic [511:0] b_o_tdata;  logic [0:0] b_o_tid;  logic b_o_tvalid, b_o_tready, b_busy;

    sha_dispatch #(.NUM_ENGINES(2), .MAX_OUTSTANDING(1), .ORDER_DEPTH(4)) dut2 (
        .clk(clk), .rst(b_rst),
        .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
        .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast),
        .m_eng_tdata(b_e_tdata), .m_eng_tkeep(b_e_tkeep), .m_eng_tlast(b_e_tlast),
        .m_eng_tvalid(b_e_tvalid), .m_eng_tready(b_e_tready),
        .s_dig_tdata(b_d_tdata), .s_dig_tvalid(b_d_tvalid), .s_dig_tready(b_d_tready),
        .m_digest_tdata(b_o_tdata), .m_digest_tid(b_o_tid),
        .m_digest_tvalid(b_o_tvalid), .m_digest_tready(b_o_tready),
        .busy(b_busy)
`ifdef SHA_DISPATCH_STATS_EN
        , .stat_pkt_count(b_stat_pkt), .stat_stall_cycles(b_stat_stall)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- reference model state ----------------
    int credit [NE];
    int oq [$];                  // engine id per granted packet, in order
    logic [511:0] exp_dig [$];   // expected digest per completed packet, in order
    bit st;                      // a packet slot is granted and streaming
    int cur, last_win, stall_m, pkts_done;
    // sender
    int plen_q [$];
    int rem, snb;
    bit pres;
    logic [511:0] sacc;
    // engine models
    logic [511:0] eacc [NE];
    int enb [NE];
    logic [511:0] edig [NE][64];
    int erdy [NE][64];
    int ewr [NE], erd [NE], dly [NE];
    bit rnd_dly;
    int rdy_pct, val_pct, otr_pct, cyc;
    // logs
    int acc_log [$];
    int pop_log [$];
    bit tready_log [$];
    bit saw_e3_wait;

    task automatic model_reset();
        for (int e = 0; e < NE; e++) begin
            credit[e] = 0; eacc[e] = '0; enb[e] = 0; ewr[e] = 0; erd[e] = 0;
        end
        oq.delete(); exp_dig.delete(); plen_q.delete();
        st = 0; cur = 0; last_win = NE - 1; stall_m = 0; pkts_done = 0;
        rem = 0; snb = 0; pres = 0; sacc = '0;
        s_tvalid = 0; s_tlast = 0; d_tvalid = '0;
    endtask

    task automatic observe();
        logic [NE-1:0] xtv, xdr;
        bit xdv, anyc, g, pop, bt;
        int h, w, idx;
        h   = (oq.size() > 0) ? oq[0] : 0;
        xtv = (st && s_tvalid) ? (NE'(1) << cur) : '0;
        xdv = (oq.size() > 0) && d_tvalid[h];
        xdr = (oq.size() > 0 && o_tready) ? (NE'(1) << h) : '0;
        anyc = st;
        for (int e = 0; e < NE; e++) anyc |= (credit[e] != 0);
        chk("s_tready", s_tready, st && e_tready[cur]);
        chk("eng_tvalid", e_tvalid, xtv);
        if (st && s_tvalid) chk("eng_tlast", e_tlast, s_tlast);
        chk("dig_tvalid", o_tvalid, xdv);
        chk("dig_tready", d_tready, xdr);
        chk("busy", busy, anyc);
        if (xdv) begin
            chk("dig_tid", o_tid, h);
            chk("dig_data", o_tdata, (exp_dig.size() > 0) ? exp_dig[0] : '0);
        end
        tready_log.push_back(s_tready);
        if (d_tvalid[3] && !d_tready[3] && oq.size() > 0 && oq[0] != 3) saw_e3_wait = 1;

        // what the coming edge does, from pre-edge state
        g = 0; w = 0;
        if (!st && oq.size() < OD)
            for (int k = 1; k <= NE; k++) begin
                idx = (last_win + k) % NE;
                if (!g && credit[idx] < MO) begin g = 1; w = idx; end
            end
        if (!st && s_tvalid && !g) stall_m++;
        pop = xdv && o_tready;
        bt  = st && s_tvalid && e_tready[cur];

        for (int e = 0; e < NE; e++) begin
            if (d_tvalid[e] && d_tready[e]) erd[e]++;
            if (e_tvalid[e] && e_tready[e]) begin
                eacc[e] ^= e_tdata ^ 512'(e_tkeep);
                enb[e]++;
                if (e_tlast) begin
                    edig[e][ewr[e] % 64] = eacc[e] ^ 512'(enb[e]);
                    erdy[e][ewr[e] % 64] = cyc + (rnd_dly ? int'($urandom_range(30, 1)) : dly[e]);
                    ewr[e]++; eacc[e] = '0; enb[e] = 0;
                end
            end
        end
        if (pop) begin
            pop_log.push_back(h);
            credit[h]--;
            oq.delete(0);
            if (exp_dig.size() > 0) exp_dig.delete(0);
        end
        if (bt) begin
            if (snb == 0) acc_log.push_back(cur);
            sacc ^= s_tdata ^ 512'(s_tkeep);
            snb++; rem--; pres = 0;
            if (s_tlast) begin
                exp_dig.push_back(sacc ^ 512'(snb));
                sacc = '0; snb = 0; st = 0; pkts_done++;
            end
        end
        if (g) begin
            credit[w]++; oq.push_back(w); last_win = w; cur = w; st = 1;
        end
    endtask

    task automatic drive();
        bit v;
        cyc++;
        for (int e = 0; e < NE; e++) e_tready[e] = ($urandom_range(99) < rdy_pct);
        o_tready = ($urandom_range(99) < otr_pct);
        for (int e = 0; e < NE; e++) begin
            v = (ewr[e] > erd[e]) && (cyc >= erdy[e][erd[e] % 64]);
            d_tvalid[e] = v;
            d_tdata[512*e +: 512] = v ? edig[e][erd[e] % 64] : '0;
        end
        if (!pres) begin
            if (rem == 0 && plen_q.size() > 0) begin rem = plen_q[0]; plen_q.delete(0); end
            if (rem > 0 && $urandom_range(99) < val_pct) begin
                pres = 1; s_tdata = rnd512(); s_tkeep = {$urandom, $urandom}; s_tlast = (rem == 1);
            end
        end
        s_tvalid = pres;
    endtask

    task automatic tick();
        @(negedge clk); observe();
        @(posedge clk); #1; drive();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_tready"}, s_tready, 1'b0);
        chk({tag, "_eng_tvalid"}, e_tvalid, '0);
        chk({tag, "_dig_tready"}, d_tready, '0);
        chk({tag, "_dig_tvalid"}, o_tvalid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; model_reset();
        @(negedge clk); chk_reset_outputs("rst");
        @(posedge clk); #1; rst = 0; drive();
    endtask

    task automatic run_until_pops(input int target, input int budget, input string tag);
        int t;
        t = 0;
        while (pop_log.size() < target && t < budget) begin tick(); t++; end
        chk(tag, pop_log.size(), target);
    endtask

    initial begin
        int base;
        rst = 1; b_rst = 1; cyc = 0; rnd_dly = 0; saw_e3_wait = 0;
        s_tdata = '0; s_tkeep = '0; d_tdata = '0; e_tready = '0; o_tready = 0;
        model_reset();
        rdy_pct = 100; val_pct = 100; otr_pct = 100;
        for (int e = 0; e < NE; e++) dly[e] = 10;

        // ---- 2 engines x 1 outstanding: third packet stalls until a pop ----
        b_s_tvalid = 1; b_s_tlast = 1; b_s_tdata = rnd512(); b_s_tkeep = '1;
        b_e_tready = 2'b11; b_d_tvalid = 2'b00; b_d_tdata = {rnd512(), rnd512()}; b_o_tready = 1;
        @(posedge clk); #1; b_rst = 0;
        @(negedge clk); chk("b_idle_tready", b_s_tready, 1'b0);
                        chk("b_idle_tvalid", b_e_tvalid, 2'b00);
        @(negedge clk); chk("b_grant0", b_e_tvalid, 2'b01);
                        chk("b_tready0", b_s_tready, 1'b1);
        @(negedge clk); chk("b_bubble", b_e_tvalid, 2'b00);
        @(negedge clk); chk("b_grant1", b_e_tvalid, 2'b10);
        @(negedge clk);
        @(negedge clk); chk("b_stall_tvalid", b_e_tvalid, 2'b00);
                        chk("b_stall_tready", b_s_tready, 1'b0);
                        chk("b_stall_busy", b_busy, 1'b1);
        @(posedge clk); #1; b_d_tvalid = 2'b01;
        @(negedge clk); chk("b_dig_valid", b_o_tvalid, 1'b1);
                        chk("b_dig_tid", b_o_tid, 1'b0);
                        chk("b_dig_ready", b_d_tready, 2'b01);
                        chk("b_dig_data", b_o_tdata, b_d_tdata[511:0]);
        @(posedge clk); #1; b_d_tvalid = 2'b00;
        @(negedge clk); chk("b_no_grant_at_pop", b_e_tvalid, 2'b00);
        @(negedge clk); chk("b_grant_after_pop", b_e_tvalid, 2'b01);
        b_rst = 1;

        // ---- reset state, stray digest valid with empty FIFO ----
        @(negedge clk); chk_reset_outputs("init");
        @(posedge clk); #1; rst = 0;
        d_tvalid = '1; d_tdata = {rnd512(), rnd512(), rnd512(), rnd512()}; o_tready = 1;
        @(negedge clk); chk("empty_dig_tvalid", o_tvalid, 1'b0);
                        chk("empty_dig_tready", d_tready, '0);
        do_reset();

        // ---- single 3-beat packet ----
        acc_log.delete(); pop_log.delete();
        plen_q.push_back(3);
        run_until_pops(1, 60, "p1_done");
        chk("p1_engine", acc_log[0], 0);
        chk("p1_tid", pop_log[0], 0);

        // ---- four 1-beat packets, engines finish 3,1,0,2 ----
        do_reset();
        acc_log.delete(); pop_log.delete(); tready_log.delete(); saw_e3_wait = 0;
        dly[0] = 30; dly[1] = 20; dly[2] = 40; dly[3] = 10;
        for (int i = 0; i < 4; i++) plen_q.push_back(1);
        run_until_pops(4, 200, "p4_done");
        for (int i = 0; i < 8; i++) chk("p4_tready_pat", tready_log[i], (i % 2));
        for (int i = 0; i < 4; i++) chk("p4_grant", acc_log[i], i);
        for (int i = 0; i < 4; i++) chk("p4_tid_order", pop_log[i], i);
        chk("p4_e3_wait", saw_e3_wait, 1'b1);

        // ---- reset during beat 2 of a 4-beat packet ----
        for (int e = 0; e < NE; e++) dly[e] = 5;
        acc_log.delete();
        plen_q.push_back(4);
        for (int t = 0; t < 40 && !(snb == 1 && pres); t++) tick();
        chk("mid_reached", snb, 1);
        rst = 1; model_reset();
        @(negedge clk); chk_reset_outputs("mid_rst");
        @(posedge clk); #1; rst = 0;
        acc_log.delete(); pop_log.delete();
        plen_q.push_back(2);
        drive();
        run_until_pops(1, 60, "post_rst_done");
        chk("post_rst_engine", acc_log[0], 0);

        // ---- randomized traffic, including back-pressure phases ----
        rnd_dly = 1;
        for (int ph = 0; ph < 2; ph++) begin
            rdy_pct = 70; val_pct = 75; otr_pct = (ph == 0) ? 60 : 5;
            base = pop_log.size();
            for (int i = 0; i < 30; i++) plen_q.push_back($urandom_range(4, 1));
            if (ph == 1) begin
                for (int t = 0; t < 400; t++) tick();
                otr_pct = 80;
            end
            run_until_pops(base + 30, 6000, "rand_done");
        end
`ifdef SHA_DISPATCH_STATS_EN
        chk("stat_stall", stat_stall, stall_m);

        // ---- stats: 5 packets on 4 engines ----
        rnd_dly = 0; rdy_pct = 100; val_pct = 100; otr_pct = 100;
        do_reset();
        for (int i = 0; i < 5; i++) plen_q.push_back(1);
        for (int t = 0; t < 100 && pkts_done < 5; t++) tick();
        @(negedge clk);
        chk("stat_pkt_count", stat_pkt, {32'd1, 32'd1, 32'd1, 32'd2});
        observe();
        @(posedge clk); #1; drive();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
